// File: rtl/clock_div_pkg.sv
`default_nettype none
// ============================================================================
// Package : clock_div_pkg
// Brief   : Shared defaults, divisor-bus slicing helper and the per-cycle
//           channel action encoding for the multi-channel clock divider.
// Rev     : 1.0 - initial release
// ============================================================================
package clock_div_pkg;

    // Default channel count and counter / divisor width
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_CNT_W  = 16;

    // A divisor of zero parks the channel: no ticks, square wave frozen
    localparam int unsigned DIV_STOP = 0;

    // What a channel does with its counter on a given cycle
    typedef enum logic [2:0] {
        ACT_HOLD  = 3'd0,   // disabled or no event: everything holds
        ACT_SYNC  = 3'd1,   // global phase-align: restart from zero
        ACT_STOP  = 3'd2,   // divisor is zero: counter parked at zero
        ACT_WRAP  = 3'd3,   // terminal count: tick, toggle, restart
        ACT_COUNT = 3'd4    // ordinary event: advance the counter
    } ch_action_e;

    // LSB position of channel ch's divisor inside the packed Div bus
    function automatic int div_lsb(input int ch, input int cnt_w);
        return ch * cnt_w;
    endfunction

endpackage : clock_div_pkg
`default_nettype wire

// File: rtl/clock_div_ch.sv
`default_nettype none
// ============================================================================
// Module : clock_div_ch
// Brief  : One divider channel. Counts qualifying events up to the active
//          divisor, emits a one-cycle tick and toggles a square wave at each
//          terminal count. A shadow divisor is loaded at any time and only
//          becomes active at a period boundary, on sync, or while stopped.
// Rev    : 1.0 - initial release
// ============================================================================
module clock_div_ch
    import clock_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_load,
    input  logic             i_enable,
    input  logic             i_sync,
    input  logic             i_ev,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] c_div_stop = CNT_W'(DIV_STOP);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shd;
    logic             r_pend;
    logic             r_tick;
    logic             r_clk_out;

    ch_action_e       w_action;
    logic             w_apply;
    logic             w_terminal;

    // Terminal count: the current event completes the period in progress
    always_comb begin
        w_terminal = (r_cnt == (r_div_act - c_one));
    end

    // Decode this cycle's action; sync beats enable, enable gates events
    always_comb begin
        w_action = ACT_HOLD;
        if (i_sync) begin
            w_action = ACT_SYNC;
        end else if (i_enable && i_ev) begin
            if (r_div_act == c_div_stop) begin
                w_action = ACT_STOP;
            end else if (w_terminal) begin
                w_action = ACT_WRAP;
            end else begin
                w_action = ACT_COUNT;
            end
        end
    end

    // A pending shadow only replaces the active divisor at a safe point,
    // so a period already under way is never truncated or stretched
    always_comb begin
        w_apply = r_pend && ((w_action == ACT_SYNC) ||
                             (w_action == ACT_STOP) ||
                             (w_action == ACT_WRAP));
    end

    // Advance the period counter and drive the registered tick / square wave
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (w_action)
                ACT_SYNC: begin
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                end
                ACT_STOP: begin
                    r_cnt <= '0;
                end
                ACT_WRAP: begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b1;
                    r_clk_out <= ~r_clk_out;
                end
                ACT_COUNT: begin
                    r_cnt <= r_cnt + c_one;
                end
                default: begin
                end
            endcase
        end
    end

    // Divisor bookkeeping: capture into the shadow, promote it when safe.
    // A load coinciding with a promotion keeps the new value pending, so
    // the old shadow lands at this boundary and the new one at the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_act <= i_div;
            r_div_shd <= i_div;
            r_pend    <= 1'b0;
        end else begin
            if (w_apply) begin
                r_div_act <= r_div_shd;
            end
            if (i_load) begin
                r_div_shd <= i_div;
                r_pend    <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_clk_out = r_clk_out;
    assign o_busy    = r_pend;

endmodule : clock_div_ch
`default_nettype wire

// File: rtl/clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module : clock_div_multi
// Brief  : Multi-channel clock-enable generator. Each channel divides the
//          system clock, or the tick of the previous channel when cascaded,
//          by a runtime-programmable ratio and provides a tick strobe, a
//          50% square wave and a pending-divisor flag.
// Rev    : 1.0 - initial release
// ============================================================================
module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter int                NUM_CH       = DEF_NUM_CH,
    parameter int                CNT_W        = DEF_CNT_W,
    parameter logic [NUM_CH-1:0] CASCADE_MASK = '0
)(
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_CH*CNT_W-1:0] Div,
    input  logic [NUM_CH-1:0]       Load,
    input  logic [NUM_CH-1:0]       Enable,
    input  logic                    Sync,
    output logic [NUM_CH-1:0]       Tick,
    output logic [NUM_CH-1:0]       Clk_out,
    output logic [NUM_CH-1:0]       Busy
);

    // Per-channel count event: every cycle, or the previous channel's tick
    logic [NUM_CH-1:0] w_ev;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Channel 0 has no predecessor, so its cascade bit is ignored.
            // A cascaded channel counts the registered tick of its
            // predecessor, which adds one cycle of phase lag but leaves the
            // period untouched.
            if ((gi == 0) || !CASCADE_MASK[gi]) begin : g_ev_free
                assign w_ev[gi] = 1'b1;
            end else begin : g_ev_casc
                assign w_ev[gi] = Tick[gi-1];
            end

            clock_div_ch #(
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk       (Clock),
                .rst       (Reset),
                .i_div     (Div[div_lsb(gi, CNT_W) +: CNT_W]),
                .i_load    (Load[gi]),
                .i_enable  (Enable[gi]),
                .i_sync    (Sync),
                .i_ev      (w_ev[gi]),
                .o_tick    (Tick[gi]),
                .o_clk_out (Clk_out[gi]),
                .o_busy    (Busy[gi])
            );
        end
    endgenerate

endmodule : clock_div_multi
`default_nettype wire

// File: tb/tb_clock_div_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_clock_div_multi
// Brief  : Self-checking bench for clock_div_multi: directed period / load /
//          enable / stop / sync scenarios plus randomized traffic, compared
//          cycle by cycle against a behavioural channel model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_clock_div_multi;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Sync  = 1'b0;
    logic [31:0] Div   = 32'd0;
    logic [31:0] Div_c = {16'd50, 16'd50};
    logic [1:0]  Load  = 2'b00;
    logic [1:0]  Enable = 2'b11;
    logic [1:0]  Tick, Clk_out, Busy;
    logic [1:0]  Tick_c, Clk_out_c, Busy_c;

    always #5 Clock = ~Clock;

    clock_div_multi #(
        .NUM_CH       (2),
        .CNT_W        (16),
        .CASCADE_MASK (2'b00)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Div     (Div),
        .Load    (Load),
        .Enable  (Enable),
        .Sync    (Sync),
        .Tick    (Tick),
        .Clk_out (Clk_out),
        .Busy    (Busy)
    );

    clock_div_multi #(
        .NUM_CH       (2),
        .CNT_W        (16),
        .CASCADE_MASK (2'b10)
    ) dut_c (
        .Clock   (Clock),
        .Reset   (Reset),
        .Div     (Div_c),
        .Load    (2'b00),
        .Enable  (2'b11),
        .Sync    (1'b0),
        .Tick    (Tick_c),
        .Clk_out (Clk_out_c),
        .Busy    (Busy_c)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural channel model: one step per clock edge
    // ------------------------------------------------------------------
    typedef struct {
        int cnt;    // events seen in the current period
        int act;    // divisor governing the current period
        int shd;    // most recently loaded divisor
        bit pend;   // shd still waiting to become act
        bit tick;
        bit clko;
    } ch_t;

    ch_t m0, m1, c0, c1;

    function automatic ch_t step(ch_t s, bit rst, bit sync, bit en, bit ev,
                                 bit load, int div);
        ch_t n;
        bit  promote;
        n       = s;
        n.tick  = 1'b0;
        promote = 1'b0;
        if (rst) begin
            n.cnt = 0; n.act = div; n.shd = div;
            n.pend = 1'b0; n.clko = 1'b0;
            return n;
        end
        if (sync) begin
            n.cnt = 0; n.clko = 1'b0; promote = s.pend;
        end else if (en && ev) begin
            if (s.act == 0) begin
                n.cnt = 0; promote = s.pend;
            end else if (s.cnt + 1 == s.act) begin
                n.cnt = 0; n.tick = 1'b1; n.clko = !s.clko; promote = s.pend;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end
        if (promote) begin
            n.act = s.shd; n.pend = 1'b0;
        end
        if (load) begin
            n.shd = div; n.pend = 1'b1;
        end
        return n;
    endfunction

    always @(posedge Clock) begin
        m0 <= step(m0, Reset, Sync, Enable[0], 1'b1, Load[0], int'(Div[15:0]));
        m1 <= step(m1, Reset, Sync, Enable[1], 1'b1, Load[1], int'(Div[31:16]));
        c0 <= step(c0, Reset, 1'b0, 1'b1, 1'b1, 1'b0, int'(Div_c[15:0]));
        c1 <= step(c1, Reset, 1'b0, 1'b1, c0.tick, 1'b0, int'(Div_c[31:16]));
    end

    bit chk_on = 1'b0;

    always @(negedge Clock) begin
        if (chk_on) begin
            check("tick",      int'(Tick),      int'({m1.tick, m0.tick}));
            check("clk_out",   int'(Clk_out),   int'({m1.clko, m0.clko}));
            check("busy",      int'(Busy),      int'({m1.pend, m0.pend}));
            check("c_tick",    int'(Tick_c),    int'({c1.tick, c0.tick}));
            check("c_clk_out", int'(Clk_out_c), int'({c1.clko, c0.clko}));
            check("c_busy",    int'(Busy_c),    int'({c1.pend, c0.pend}));
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic do_reset(input logic [31:0] div);
        @(negedge Clock);
        Reset = 1'b1; Div = div; Load = 2'b00; Sync = 1'b0; Enable = 2'b11;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Cycle offsets (1 = next cycle) of the first two ticks per channel
    task automatic run_ticks(input int ncyc, output int f0, output int s0,
                             output int f1, output int s1);
        f0 = -1; s0 = -1; f1 = -1; s1 = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge Clock);
            if (Tick[0]) begin
                if (f0 < 0) f0 = k; else if (s0 < 0) s0 = k;
            end
            if (Tick[1]) begin
                if (f1 < 0) f1 = k; else if (s1 < 0) s1 = k;
            end
        end
    endtask

    int f0, s0, f1, s1;
    int first0, nt0, nt1, hi0, hi1, cf, cs, chi, nfrz;

    initial begin
        Div = {16'd5, 16'd3};
        repeat (2) @(negedge Clock);
        check("rst_tick",    int'(Tick),    0);
        check("rst_clk_out", int'(Clk_out), 0);
        check("rst_busy",    int'(Busy),    0);
        Reset  = 1'b0;
        chk_on = 1'b1;

        // Free-running 3 / 5 and the cascaded 50 x 50 divider
        first0 = -1; nt0 = 0; nt1 = 0; hi0 = 0; hi1 = 0;
        cf = -1; cs = -1; chi = 0;
        for (int k = 1; k <= 5100; k++) begin
            @(negedge Clock);
            if (k <= 30) begin
                if (Tick[0]) begin
                    if (first0 < 0) first0 = k;
                    nt0++;
                end
                if (Tick[1])    nt1++;
                if (Clk_out[0]) hi0++;
                if (Clk_out[1]) hi1++;
            end
            if (Tick_c[1]) begin
                if (cf < 0) cf = k; else if (cs < 0) cs = k;
            end
            if (Clk_out_c[1]) chi++;
        end
        check("first_tick0",   first0, 3);
        check("ticks0_30cyc",  nt0, 10);
        check("ticks1_30cyc",  nt1, 6);
        check("clk0_high_30",  hi0, 15);
        check("clk1_high_30",  hi1, 15);
        check("casc_first",    cf, 2501);
        check("casc_period",   cs - cf, 2500);
        check("casc_clk_high", chi, 2500);

        // Load a new divisor mid-period
        do_reset({16'd5, 16'd4});
        @(negedge Clock);
        Load = 2'b01; Div = {16'd5, 16'd2};
        @(negedge Clock);
        Load = 2'b00;
        check("load_busy_set", int'(Busy[0]), 1);
        @(negedge Clock);
        check("load_busy_hold", int'(Busy[0]), 1);
        check("load_no_early_tick", int'(Tick[0]), 0);
        run_ticks(5, f0, s0, f1, s1);
        check("load_keep_period", f0, 1);
        check("load_new_period",  s0 - f0, 2);
        check("load_busy_clear",  int'(Busy[0]), 0);

        // Enable low for 7 cycles with the counter at 2
        do_reset({16'd5, 16'd4});
        repeat (2) @(negedge Clock);
        Enable = 2'b10;
        nfrz = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge Clock);
            if (Tick[0]) nfrz++;
        end
        Enable = 2'b11;
        check("frz_no_tick", nfrz, 0);
        check("frz_clk_out", int'(Clk_out[0]), 0);
        run_ticks(6, f0, s0, f1, s1);
        check("frz_resume", f0, 2);
        check("frz_period", s0 - f0, 4);

        // Stopped channel, then load a real divisor
        do_reset({16'd5, 16'd0});
        nfrz = 0; hi0 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (Tick[0])    nfrz++;
            if (Clk_out[0]) hi0++;
        end
        check("stop_no_tick", nfrz, 0);
        check("stop_clk_low", hi0, 0);
        Load = 2'b01; Div = {16'd5, 16'd3};
        @(negedge Clock);
        Load = 2'b00;
        check("stop_busy_set", int'(Busy[0]), 1);
        @(negedge Clock);
        check("stop_busy_clear", int'(Busy[0]), 0);
        run_ticks(5, f0, s0, f1, s1);
        check("stop_first_tick", f0, 3);

        // Sync at an arbitrary phase, with a load on channel 1
        do_reset({16'd5, 16'd3});
        repeat ($urandom_range(7, 20)) @(negedge Clock);
        Sync = 1'b1; Load = 2'b10; Div = {16'd7, 16'd3};
        @(negedge Clock);
        Sync = 1'b0; Load = 2'b00;
        check("sync_tick",    int'(Tick),    0);
        check("sync_clk_out", int'(Clk_out), 0);
        check("sync_busy",    int'(Busy),    2);
        run_ticks(14, f0, s0, f1, s1);
        check("sync_t0_first",  f0, 3);
        check("sync_t0_second", s0, 6);
        check("sync_t1_first",  f1, 5);
        check("sync_t1_second", s1, 12);
        check("sync_busy_end",  int'(Busy), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clock);
            Reset  = ($urandom_range(0, 199) == 0);
            Sync   = ($urandom_range(0, 49) == 0);
            Load   = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            Enable = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
            Div    = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
        end
        @(negedge Clock);
        Reset = 1'b0; Sync = 1'b0; Load = 2'b00; Enable = 2'b11;
        repeat (20) @(negedge Clock);
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clock_div_multi
`default_nettype wire
